// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the instruction-fetch port (I)
// and the data load/store port (D). Only one transaction is ever in flight.
// D wins contention unless I has lost STARVE_LIMIT times in a row. A
// watchdog ends any transaction the memory does not complete within
// TIMEOUT_CYCLES of entering ISSUE. Setting TIMEOUT_CYCLES to 0 disables it.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   i_req/i_addr -> i_gnt          fetch request and one-cycle capture pulse
//   i_rvalid/i_rdata               fetch completion pulse and data
//   d_req/d_addr/d_we/d_wdata/d_type -> d_gnt   data request and capture pulse
//   d_rvalid/d_rdata               load data or store completion pulse
//   mem_req/addr/we/wdata/type     held memory request
//   mem_gnt/mem_rvalid/mem_rdata   memory accept, completion, read data
//   err_timeout                    one-cycle pulse on watchdog expiry
//   busy                           a transaction is in ISSUE or WAIT
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_type,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_type,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        err_timeout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [7:0]  STARVE_MAX = 8'(STARVE_LIMIT);
  localparam bit          TMO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST   = TMO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t      state_reg, state_next;
  logic [7:0]  starve_cnt_reg;
  logic [31:0] tmo_cnt_reg;
  logic        owner_i_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic        we_reg;
  logic [2:0]  type_reg;
  logic        i_rvalid_reg, d_rvalid_reg, err_reg;
  logic [31:0] i_rdata_reg, d_rdata_reg;

  logic capture, pick_i, complete, expire, active;

  // I wins only when alone or when it has been starved to the limit.
  assign pick_i   = i_req && (!d_req || (starve_cnt_reg == STARVE_MAX));
  assign capture  = (state_reg == IDLE) && (i_req || d_req);
  assign active   = (state_reg == ISSUE) || (state_reg == WAIT);
  // A zero-wait memory may accept and complete in the same ISSUE cycle.
  assign complete = ((state_reg == ISSUE) && mem_gnt && mem_rvalid) ||
                    ((state_reg == WAIT) && mem_rvalid);
  // Completion in the expiry cycle takes precedence over the watchdog.
  assign expire   = TMO_EN && active && (tmo_cnt_reg == TMO_LAST) && !complete;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (capture) state_next = ISSUE;
      ISSUE: begin
        if (complete || expire) state_next = IDLE;
        else if (mem_gnt)       state_next = WAIT;
      end
      WAIT:    if (complete || expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. Grants are gated by rst so every output is low while
  // reset is asserted, even with a request already present.
  always_comb begin
    i_gnt   = !rst && capture && pick_i;
    d_gnt   = !rst && capture && !pick_i;
    mem_req = (state_reg == ISSUE);
    busy    = (state_reg != IDLE);
  end

  assign mem_addr    = addr_reg;
  assign mem_we      = we_reg;
  assign mem_wdata   = wdata_reg;
  assign mem_type    = type_reg;
  assign i_rvalid    = i_rvalid_reg;
  assign i_rdata     = i_rdata_reg;
  assign d_rvalid    = d_rvalid_reg;
  assign d_rdata     = d_rdata_reg;
  assign err_timeout = err_reg;

  // Capture, arbitration history and watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_reg <= 8'd0;
      tmo_cnt_reg    <= 32'd0;
      owner_i_reg    <= 1'b0;
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
      we_reg         <= 1'b0;
      type_reg       <= 3'd0;
    end else begin
      if (capture) begin
        owner_i_reg <= pick_i;
        tmo_cnt_reg <= 32'd0;
        if (pick_i) begin
          addr_reg       <= i_addr;
          wdata_reg      <= 32'd0;
          we_reg         <= 1'b0;
          type_reg       <= 3'b010;
          starve_cnt_reg <= 8'd0;
        end else begin
          addr_reg  <= d_addr;
          wdata_reg <= d_wdata;
          we_reg    <= d_we;
          type_reg  <= d_type;
          if (i_req && (starve_cnt_reg != STARVE_MAX))
            starve_cnt_reg <= starve_cnt_reg + 8'd1;
        end
      end else if (active) begin
        tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
      end
    end
  end

  // Registered completion: rvalid follows the sampled mem_rvalid by a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rvalid_reg <= 1'b0;
      d_rvalid_reg <= 1'b0;
      err_reg      <= 1'b0;
      i_rdata_reg  <= 32'd0;
      d_rdata_reg  <= 32'd0;
    end else begin
      i_rvalid_reg <= (complete || expire) && owner_i_reg;
      d_rvalid_reg <= (complete || expire) && !owner_i_reg;
      err_reg      <= expire;
      if (complete) begin
        if (owner_i_reg) i_rdata_reg <= mem_rdata;
        else             d_rdata_reg <= mem_rdata;
      end else if (expire) begin
        if (owner_i_reg) i_rdata_reg <= 32'd0;
        else             d_rdata_reg <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic        d_we = 1'b0;
  logic [31:0] d_wdata = 32'd0;
  logic [2:0]  d_type = 3'd0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_type;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        err_timeout, busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_type(d_type),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_type(mem_type), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // {i_gnt, d_gnt, mem_req, i_rvalid, d_rvalid, err_timeout, busy}
  function automatic logic [6:0] flags();
    return {i_gnt, d_gnt, mem_req, i_rvalid, d_rvalid, err_timeout, busy};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks follow 2 ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req = 0; i_addr = 0; d_req = 0; d_addr = 0; d_we = 0; d_wdata = 0; d_type = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    clear_inputs();
    #2;
    chk("reset_flags", 64'(flags()), 64'd0);
    next_cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        i_req;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [6:0]  exp_flags;
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_mem_addr;
    logic [3:0]  exp_mem_ctl;   // {mem_we, mem_type}
  } vec_t;

  vec_t vecs [7];
  string grant_seq [10];
  string exp_seq [10];
  int n_gnt;

  initial begin
    // Fetch from 0x100: memory accepts one cycle after mem_req and
    // completes two cycles after accepting.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0,        7'b1000000, 32'h0,        32'h0,   4'b0000};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h0,        7'b0010001, 32'h0,        32'h100, 4'b0010};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,        7'b0010001, 32'h0,        32'h100, 4'b0010};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h0,        7'b0000001, 32'h0,        32'h100, 4'b0010};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 7'b0000001, 32'h0,        32'h100, 4'b0010};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h11111111, 7'b0001000, 32'hDEADBEEF, 32'h100, 4'b0010};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h0,        7'b0000000, 32'hDEADBEEF, 32'h100, 4'b0010};
    exp_seq = '{"D", "D", "D", "D", "I", "D", "D", "D", "D", "I"};

    // Reset state
    #2;
    chk("rst_flags", 64'(flags()), 64'd0);
    chk("rst_mem_fields", {mem_addr, mem_wdata}, 64'd0);
    chk("rst_rdata", {i_rdata, d_rdata}, 64'd0);
    chk("rst_mem_ctl", 64'({mem_we, mem_type}), 64'd0);
    next_cycle();
    rst = 1'b0;

    // Table: single fetch
    i_addr = 32'h100;
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      i_req      = vecs[i].i_req;
      mem_gnt    = vecs[i].mem_gnt;
      mem_rvalid = vecs[i].mem_rvalid;
      mem_rdata  = vecs[i].mem_rdata;
      #2;
      chk($sformatf("fetch%0d_flags", i), 64'(flags()), 64'(vecs[i].exp_flags));
      chk($sformatf("fetch%0d_i_rdata", i), 64'(i_rdata), 64'(vecs[i].exp_i_rdata));
      chk($sformatf("fetch%0d_mem", i), {mem_addr, 28'd0, mem_we, mem_type},
          {vecs[i].exp_mem_addr, 28'd0, vecs[i].exp_mem_ctl});
    end

    // Store with a pending fetch: fetch must wait for the store to finish
    next_cycle();
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_type = 3'b010;
    i_req = 1; i_addr = 32'h300; mem_gnt = 0; mem_rvalid = 0;
    #2;
    chk("store_gnt", 64'({i_gnt, d_gnt}), 64'b01);
    next_cycle();
    d_req = 0; d_we = 0; d_addr = 32'hFFFF; d_wdata = 32'h0; d_type = 3'b000; mem_gnt = 1;
    #2;
    chk("store_mem_aw", {mem_addr, mem_wdata}, {32'h2000, 32'h12345678});
    chk("store_mem_ctl", 64'({mem_req, mem_we, mem_type, i_gnt}), 64'({1'b1, 1'b1, 3'b010, 1'b0}));
    next_cycle();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hAAAA0000;
    #2;
    chk("store_wait", 64'({i_gnt, mem_req, d_rvalid}), 64'b000);
    next_cycle();
    mem_rvalid = 0;
    #2;
    chk("store_done", 64'({d_rvalid, i_rvalid, i_gnt, d_gnt}), 64'b1010);

    // Fetch completes with gnt+rvalid together; waiting D captured on rvalid
    next_cycle();
    i_req = 0; d_req = 1; d_we = 0; d_addr = 32'h400; d_type = 3'b100;
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    #2;
    chk("fast_issue", {mem_addr, 24'd0, 2'b0, mem_req, mem_we, mem_type, d_gnt},
        {32'h300, 24'd0, 2'b0, 1'b1, 1'b0, 3'b010, 1'b0});
    next_cycle();
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 32'h0;
    #2;
    chk("fast_rvalid", {i_rdata, 28'd0, i_rvalid, d_rvalid, d_gnt, i_gnt},
        {32'hCAFEF00D, 28'd0, 4'b1010});
    next_cycle();
    d_req = 0; mem_gnt = 1;
    #2;
    chk("load_issue", {mem_addr, 28'd0, mem_we, mem_type}, {32'h400, 28'd0, 1'b0, 3'b100});
    next_cycle();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
    next_cycle();
    mem_rvalid = 0;
    #2;
    chk("load_done", {d_rdata, 29'd0, d_rvalid, i_rvalid, err_timeout},
        {32'h55AA55AA, 29'd0, 3'b100});

    // Watchdog: memory never accepts
    next_cycle();
    d_req = 1; d_addr = 32'h500;
    #2;
    chk("tmo_gnt", 64'(d_gnt), 64'd1);
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      d_req = 0;
      #2;
      chk($sformatf("tmo_issue%0d", k), 64'({mem_req, err_timeout, d_rvalid}), 64'b100);
    end
    next_cycle();
    #2;
    chk("tmo_expire", {d_rdata, 28'd0, err_timeout, d_rvalid, mem_req, busy},
        {32'h0, 28'd0, 4'b1100});
    next_cycle();
    mem_rvalid = 1; mem_gnt = 1; mem_rdata = 32'h99999999;
    #2;
    chk("late_resp_in", 64'({err_timeout, d_rvalid, i_rvalid, busy}), 64'b0000);
    next_cycle();
    mem_rvalid = 0; mem_gnt = 0;
    #2;
    chk("late_resp_out", 64'({d_rvalid, i_rvalid, busy, mem_req}), 64'b0000);

    // Starvation: both ports request continuously, zero-wait memory
    do_reset();
    i_req = 1; d_req = 1; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h1;
    n_gnt = 0;
    for (int c = 0; c < 40 && n_gnt < 10; c++) begin
      #2;
      if (d_gnt) begin grant_seq[n_gnt] = "D"; n_gnt++; end
      else if (i_gnt) begin grant_seq[n_gnt] = "I"; n_gnt++; end
      next_cycle();
    end
    chk("grant_count", 64'(n_gnt), 64'd10);
    for (int g = 0; g < n_gnt; g++)
      chk($sformatf("grant%0d_is_%s", g, exp_seq[g]),
          64'(grant_seq[g] == "I"), 64'(exp_seq[g] == "I"));

    // Reset while waiting on the memory
    do_reset();
    i_req = 1; i_addr = 32'h600;
    #2;
    chk("rw_gnt", 64'(i_gnt), 64'd1);
    next_cycle();
    i_req = 0; mem_gnt = 1;
    next_cycle();
    mem_gnt = 0;
    #2;
    chk("rw_in_wait", 64'({busy, mem_req}), 64'b10);
    rst = 1; i_req = 1; i_addr = 32'h700;
    #1;
    chk("rw_async_flags", 64'(flags()), 64'd0);
    chk("rw_async_mem", {mem_addr, mem_wdata}, 64'd0);
    next_cycle();
    mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    #2;
    chk("rw_held", 64'(flags()), 64'd0);
    next_cycle();
    rst = 0; mem_rvalid = 0;
    #2;
    chk("rw_release", 64'(flags()), 64'b1000000);
    next_cycle();
    i_req = 0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h77;
    #2;
    chk("rw_issue", {mem_addr, 31'd0, i_rvalid}, {32'h700, 32'd0});
    next_cycle();
    mem_gnt = 0; mem_rvalid = 0;
    #2;
    chk("rw_done", {i_rdata, 30'd0, i_rvalid, d_rvalid}, {32'h77, 30'd0, 2'b10});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
